// File: rtl/bp_me_pkg.sv
// bp_me_pkg: shared configuration widths, destination tags and local-address decode constants
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_inv_cfg     = 2'd1
  } bp_params_e;

  typedef enum logic [1:0] {
    e_dest_clint = 2'd0,
    e_dest_cfg   = 2'd1,
    e_dest_null  = 2'd2
  } bp_local_demux_dest_e;

  localparam int msg_type_width_gp = 4;
  localparam int payload_width_gp  = 4;
  localparam int size_width_gp     = 3;

  // Device select field inside a tile-local physical address
  localparam int dev_offset_gp = 20;
  localparam int dev_width_gp  = 4;

  localparam logic [dev_width_gp-1:0] clint_dev_gp = 4'd1;
  localparam logic [dev_width_gp-1:0] cfg_dev_gp   = 4'd0;

  function automatic int paddr_width(bp_params_e p);
    return p == e_bp_default_cfg ? 56 : 40;
  endfunction

  function automatic int cce_block_width(bp_params_e p);
    return p == e_bp_default_cfg ? 512 : 64;
  endfunction

  function automatic int mem_header_width(bp_params_e p);
    return msg_type_width_gp + paddr_width(p) + payload_width_gp + size_width_gp + 1;
  endfunction

endpackage

// File: rtl/bp_local_tag_fifo.sv
// bp_local_tag_fifo: 2-bit destination tag FIFO, depth_p entries, async active-low reset
module bp_local_tag_fifo #(
  parameter int depth_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       push_i,
  input  logic [1:0] data_i,
  input  logic       pop_i,
  output logic [1:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int ptr_w = depth_p > 1 ? $clog2(depth_p) : 1;
  localparam int cnt_w = $clog2(depth_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);

  logic [1:0]       mem [depth_p];
  logic [ptr_w-1:0] wr_ptr, rd_ptr;
  logic [cnt_w-1:0] count;
  logic             do_push, do_pop;

  assign full_o  = count == cnt_w'(depth_p);
  assign empty_o = count == '0;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == last_ptr ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == last_ptr ? '0 : rd_ptr + 1'b1;
      count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bp_local_cmd_demux.sv
// bp_local_cmd_demux: steers local commands to CLINT/config/null and returns responses in order
// Optional: BP_LOCAL_DEMUX_UNMAPPED_ERR_EN enables the sticky unmapped flag and all-ones null data
module bp_local_cmd_demux
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int max_outstanding_p = 4,
  localparam int cce_mem_msg_width_lp = mem_header_width(bp_params_p) + cce_block_width(bp_params_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] clint_cmd_o,
  output logic                            clint_cmd_v_o,
  input  logic                            clint_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] clint_resp_i,
  input  logic                            clint_resp_v_i,
  output logic                            clint_resp_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] cfg_cmd_o,
  output logic                            cfg_cmd_v_o,
  input  logic                            cfg_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] cfg_resp_i,
  input  logic                            cfg_resp_v_i,
  output logic                            cfg_resp_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i,
  output logic                            unmapped_err_o
);

  localparam int paddr_width_p     = paddr_width(bp_params_p);
  localparam int cce_block_width_p = cce_block_width(bp_params_p);
  localparam int hdr_width_lp      = mem_header_width(bp_params_p);

  typedef struct packed {
    logic [msg_type_width_gp-1:0] msg_type;
    logic [paddr_width_p-1:0]     addr;
    logic [payload_width_gp-1:0]  payload;
    logic [size_width_gp-1:0]     size;
    logic                         amo_no_return;
  } mem_header_s;

  mem_header_s                  cmd_hdr, null_hdr;
  bp_local_demux_dest_e         sel, head;
  logic [dev_width_gp-1:0]      dev;
  logic [1:0]                   head_raw;
  logic [cce_block_width_p-1:0] null_data;
  logic tag_full, tag_empty, tag_v, null_v, sel_ready;
  logic cmd_accept, null_accept, resp_fire;

  assign cmd_hdr = mem_cmd_i[cce_mem_msg_width_lp-1 -: hdr_width_lp];
  assign dev     = cmd_hdr.addr[dev_offset_gp +: dev_width_gp];
  assign sel     = dev == clint_dev_gp ? e_dest_clint
                 : dev == cfg_dev_gp   ? e_dest_cfg
                 :                       e_dest_null;

  // Command side: passthrough, gated by registered full so v_o never waits on ready_i
  assign clint_cmd_o     = mem_cmd_i;
  assign cfg_cmd_o       = mem_cmd_i;
  assign clint_cmd_v_o   = reset_n_i & mem_cmd_v_i & ~tag_full & (sel == e_dest_clint);
  assign cfg_cmd_v_o     = reset_n_i & mem_cmd_v_i & ~tag_full & (sel == e_dest_cfg);
  assign sel_ready       = sel == e_dest_clint ? clint_cmd_ready_i
                         : sel == e_dest_cfg   ? cfg_cmd_ready_i
                         :                       ~null_v;
  assign mem_cmd_ready_o = reset_n_i & ~tag_full & sel_ready;
  assign cmd_accept      = mem_cmd_v_i & mem_cmd_ready_o;
  assign null_accept     = cmd_accept & (sel == e_dest_null);

  bp_local_tag_fifo #(.depth_p(max_outstanding_p)) tag_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (cmd_accept),
    .data_i   (sel),
    .pop_i    (resp_fire),
    .data_o   (head_raw),
    .full_o   (tag_full),
    .empty_o  (tag_empty)
  );

  // Response side: only the head tag's source is visible or acknowledged
  assign head              = bp_local_demux_dest_e'(head_raw);
  assign tag_v             = ~tag_empty;
  assign mem_resp_v_o      = tag_v & (head == e_dest_clint ? clint_resp_v_i
                                    : head == e_dest_cfg   ? cfg_resp_v_i
                                    :                        null_v);
  assign mem_resp_o        = head == e_dest_clint ? clint_resp_i
                           : head == e_dest_cfg   ? cfg_resp_i
                           :                        {null_hdr, null_data};
  assign resp_fire         = mem_resp_yumi_i & mem_resp_v_o;
  assign clint_resp_yumi_o = resp_fire & (head == e_dest_clint);
  assign cfg_resp_yumi_o   = resp_fire & (head == e_dest_cfg);

  // Capture is blocked while occupied, so capture and release never coincide
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      null_v   <= 1'b0;
      null_hdr <= '0;
    end else if (null_accept) begin
      null_v   <= 1'b1;
      null_hdr <= cmd_hdr;
    end else if (resp_fire & (head == e_dest_null)) begin
      null_v   <= 1'b0;
    end
  end

`ifdef BP_LOCAL_DEMUX_UNMAPPED_ERR_EN
  logic err_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_r <= 1'b0;
    else if (null_accept) err_r <= 1'b1;
  end

  assign unmapped_err_o = err_r;
  assign null_data      = '1;
`else
  assign unmapped_err_o = 1'b0;
  assign null_data      = '0;
`endif

endmodule

// File: tb/tb_bp_local_cmd_demux.sv
// tb_bp_local_cmd_demux: directed self-checking bench for bp_local_cmd_demux
module tb_bp_local_cmd_demux;
  import bp_me_pkg::*;

  localparam int W = 116;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [W-1:0] mem_cmd_i, clint_cmd_o, clint_resp_i, cfg_cmd_o, cfg_resp_i, mem_resp_o;
  logic mem_cmd_v_i, mem_cmd_ready_o, clint_cmd_v_o, clint_cmd_ready_i, clint_resp_v_i, clint_resp_yumi_o;
  logic cfg_cmd_v_i_unused, cfg_cmd_v_o, cfg_cmd_ready_i, cfg_resp_v_i, cfg_resp_yumi_o;
  logic mem_resp_v_o, mem_resp_yumi_i, unmapped_err_o;

  int n_cmp = 0;
  int n_err = 0;

`ifdef BP_LOCAL_DEMUX_UNMAPPED_ERR_EN
  localparam logic [63:0] null_d = '1;
  localparam logic        err_exp = 1'b1;
`else
  localparam logic [63:0] null_d = '0;
  localparam logic        err_exp = 1'b0;
`endif

  bp_local_cmd_demux dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .mem_cmd_i        (mem_cmd_i),
    .mem_cmd_v_i      (mem_cmd_v_i),
    .mem_cmd_ready_o  (mem_cmd_ready_o),
    .clint_cmd_o      (clint_cmd_o),
    .clint_cmd_v_o    (clint_cmd_v_o),
    .clint_cmd_ready_i(clint_cmd_ready_i),
    .clint_resp_i     (clint_resp_i),
    .clint_resp_v_i   (clint_resp_v_i),
    .clint_resp_yumi_o(clint_resp_yumi_o),
    .cfg_cmd_o        (cfg_cmd_o),
    .cfg_cmd_v_o      (cfg_cmd_v_o),
    .cfg_cmd_ready_i  (cfg_cmd_ready_i),
    .cfg_resp_i       (cfg_resp_i),
    .cfg_resp_v_i     (cfg_resp_v_i),
    .cfg_resp_yumi_o  (cfg_resp_yumi_o),
    .mem_resp_o       (mem_resp_o),
    .mem_resp_v_o     (mem_resp_v_o),
    .mem_resp_yumi_i  (mem_resp_yumi_i),
    .unmapped_err_o   (unmapped_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [3:0] t, input logic [39:0] a, input logic [3:0] p,
                                      input logic [2:0] s, input logic amo, input logic [63:0] d);
    return {t, a, p, s, amo, d};
  endfunction

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic idle();
    mem_cmd_v_i = 0; clint_resp_v_i = 0; cfg_resp_v_i = 0; mem_resp_yumi_i = 0;
  endtask

  localparam logic [39:0] a_mtime = 40'h00_0010_bff8;
  localparam logic [39:0] a_cfg   = 40'h00_0000_0040;

  logic [W-1:0] c_clint, c_cfg, c_n1, c_n2;

  initial begin
    c_clint = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h0);
    c_cfg   = mk(4'h0, a_cfg, 4'h0, 3'd3, 1'b0, 64'h0);
    c_n1    = mk(4'h1, 40'h00_0070_0123, 4'h5, 3'd2, 1'b1, 64'hdead);
    c_n2    = mk(4'h2, 40'h00_00f0_0008, 4'ha, 3'd1, 1'b0, 64'hbeef);
    cfg_cmd_v_i_unused = 0;
    clint_resp_i = '0; cfg_resp_i = '0;
    // Reset held with every input asserted: all handshake outputs must stay low
    reset_n_i = 0; mem_cmd_i = c_clint; mem_cmd_v_i = 1; clint_cmd_ready_i = 1; cfg_cmd_ready_i = 1;
    clint_resp_v_i = 1; cfg_resp_v_i = 1; mem_resp_yumi_i = 1;
    cyc(); #1;
    chk("rst_ready", mem_cmd_ready_o, 0);
    chk("rst_clint_v", clint_cmd_v_o, 0);
    chk("rst_cfg_v", cfg_cmd_v_o, 0);
    chk("rst_resp_v", mem_resp_v_o, 0);
    chk("rst_yumi", clint_resp_yumi_o, 0);
    chk("rst_err", unmapped_err_o, 0);
    idle(); reset_n_i = 1;

    // Single CLINT read, response 3 cycles later
    cyc(); mem_cmd_i = c_clint; mem_cmd_v_i = 1; #1;
    chk("t1_clint_v", clint_cmd_v_o, 1);
    chk("t1_cfg_v", cfg_cmd_v_o, 0);
    chk("t1_ready", mem_cmd_ready_o, 1);
    chk("t1_clint_cmd", clint_cmd_o, c_clint);
    cyc(); mem_cmd_v_i = 0; #1;
    chk("t1_no_resp", mem_resp_v_o, 0);
    cyc(); cyc();
    clint_resp_v_i = 1; clint_resp_i = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h40); mem_resp_yumi_i = 1; #1;
    chk("t1_resp_v", mem_resp_v_o, 1);
    chk("t1_resp", mem_resp_o, mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h40));
    chk("t1_clint_yumi", clint_resp_yumi_o, 1);
    chk("t1_cfg_yumi", cfg_resp_yumi_o, 0);
    cyc(); #1;
    chk("t1_empty_v", mem_resp_v_o, 0);
    chk("t1_empty_yumi", clint_resp_yumi_o, 0);
    idle();

    // CFG then CLINT; CLINT answers first and must wait
    cyc(); mem_cmd_i = c_cfg; mem_cmd_v_i = 1; #1;
    chk("t2_cfg_v", cfg_cmd_v_o, 1);
    chk("t2_cfg_ready", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_i = c_clint; #1;
    chk("t2_clint_ready", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_v_i = 0; clint_resp_v_i = 1; clint_resp_i = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h22);
    mem_resp_yumi_i = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_hold_v", mem_resp_v_o, 0);
      chk("t2_hold_yumi", clint_resp_yumi_o, 0);
      cyc();
    end
    cfg_resp_v_i = 1; cfg_resp_i = mk(4'h0, a_cfg, 4'h0, 3'd3, 1'b0, 64'h11); #1;
    chk("t2_first", mem_resp_o[63:0], 64'h11);
    chk("t2_cfg_yumi", cfg_resp_yumi_o, 1);
    chk("t2_clint_wait", clint_resp_yumi_o, 0);
    cyc(); cfg_resp_v_i = 0; #1;
    chk("t2_second", mem_resp_o[63:0], 64'h22);
    chk("t2_clint_yumi", clint_resp_yumi_o, 1);
    cyc(); idle();

    // Fill all four tags, then one pop reopens ready next cycle
    for (int i = 0; i < 4; i++) begin
      cyc(); mem_cmd_i = c_clint; mem_cmd_v_i = 1; #1;
      chk("t3_fill_ready", mem_cmd_ready_o, 1);
    end
    cyc(); clint_resp_v_i = 1; clint_resp_i = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h33); mem_resp_yumi_i = 1; #1;
    chk("t3_full_ready", mem_cmd_ready_o, 0);
    chk("t3_full_clint_v", clint_cmd_v_o, 0);
    chk("t3_full_resp_v", mem_resp_v_o, 1);
    cyc(); clint_resp_v_i = 0; mem_resp_yumi_i = 0; #1;
    chk("t3_reopen", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_v_i = 0; clint_resp_v_i = 1; mem_resp_yumi_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("t3_drain_v", mem_resp_v_o, 1);
      cyc();
    end
    #1; chk("t3_drained", mem_resp_v_o, 0);
    idle();

    // Unmapped device: echoed header, fixed data, single-entry null buffer
    cyc(); mem_cmd_i = c_n1; mem_cmd_v_i = 1; #1;
    chk("t4_ready", mem_cmd_ready_o, 1);
    chk("t4_clint_v", clint_cmd_v_o, 0);
    chk("t4_cfg_v", cfg_cmd_v_o, 0);
    cyc(); mem_cmd_i = c_n2; mem_resp_yumi_i = 1; #1;
    chk("t4_resp_v", mem_resp_v_o, 1);
    chk("t4_resp", mem_resp_o, {c_n1[W-1:64], null_d});
    chk("t4_busy", mem_cmd_ready_o, 0);
    chk("t4_err", unmapped_err_o, err_exp);
    cyc(); #1;
    chk("t4_free", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_v_i = 0; #1;
    chk("t4_resp2", mem_resp_o, {c_n2[W-1:64], null_d});
    cyc(); mem_resp_yumi_i = 0; #1;
    chk("t4_done", mem_resp_v_o, 0);
    chk("t4_err_hold", unmapped_err_o, err_exp);
    idle();

    // Reset asserted with two tags outstanding
    cyc(); mem_cmd_i = c_cfg; mem_cmd_v_i = 1;
    cyc(); mem_cmd_i = c_clint;
    cyc(); mem_cmd_v_i = 0; cfg_resp_v_i = 1; clint_resp_v_i = 1; #1;
    chk("t5_pre_v", mem_resp_v_o, 1);
    reset_n_i = 0; mem_cmd_v_i = 1; mem_resp_yumi_i = 1; #1;
    chk("t5_rst_resp_v", mem_resp_v_o, 0);
    chk("t5_rst_yumi", cfg_resp_yumi_o, 0);
    chk("t5_rst_clint_v", clint_cmd_v_o, 0);
    chk("t5_rst_ready", mem_cmd_ready_o, 0);
    chk("t5_rst_err", unmapped_err_o, 0);
    cyc(); reset_n_i = 1; mem_cmd_v_i = 0; #1;
    chk("t5_no_stale", mem_resp_v_o, 0);
    chk("t5_no_yumi", clint_resp_yumi_o, 0);
    cyc(); idle(); mem_cmd_i = c_clint; mem_cmd_v_i = 1; #1;
    chk("t5_new_ready", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_v_i = 0; clint_resp_v_i = 1; clint_resp_i = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h55);
    mem_resp_yumi_i = 1; #1;
    chk("t5_new_resp", mem_resp_o[63:0], 64'h55);
    cyc(); idle();

    // Target backpressure: valid held, no push until ready
    cyc(); clint_cmd_ready_i = 0; mem_cmd_i = c_clint; mem_cmd_v_i = 1; clint_resp_v_i = 1;
    clint_resp_i = mk(4'h0, a_mtime, 4'h0, 3'd3, 1'b0, 64'h66);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t6_v_held", clint_cmd_v_o, 1);
      chk("t6_not_ready", mem_cmd_ready_o, 0);
      chk("t6_no_tag", mem_resp_v_o, 0);
      cyc();
    end
    clint_cmd_ready_i = 1; #1;
    chk("t6_ready", mem_cmd_ready_o, 1);
    cyc(); mem_cmd_v_i = 0; mem_resp_yumi_i = 1; #1;
    chk("t6_resp_v", mem_resp_v_o, 1);
    chk("t6_resp", mem_resp_o[63:0], 64'h66);
    chk("t6_yumi", clint_resp_yumi_o, 1);
    cyc(); idle(); #1;
    chk("t6_done", mem_resp_v_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_local_cmd_demux.md
Name: bp_local_cmd_demux

Overview:
- Sits directly upstream of the CLINT slice, inside the tile's local-device region.
- Accepts one stream of uncached memory commands and steers each command by its local-address device field to one of three targets: the CLINT slice, the config slice, or an internal null responder.
- Merges the responses back into a single response stream in strict command order.
- Tracks the destination of every in-flight command in a tag FIFO.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor configuration; supplies paddr_width_p, cce_block_width_p and the derived cce_mem_msg_width_lp.
- max_outstanding_p, 4, tag FIFO depth; maximum number of commands accepted but not yet answered.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- mem_cmd_i  in  cce_mem_msg_width_lp  command from upstream.
- mem_cmd_v_i  in  1  command valid.
- mem_cmd_ready_o  out  1  command accepted when v & ready.
- clint_cmd_o  out  cce_mem_msg_width_lp  command to CLINT slice.
- clint_cmd_v_o  out  1
- clint_cmd_ready_i  in  1
- clint_resp_i  in  cce_mem_msg_width_lp  response from CLINT slice.
- clint_resp_v_i  in  1
- clint_resp_yumi_o  out  1
- cfg_cmd_o / cfg_cmd_v_o / cfg_cmd_ready_i  same shape, to config slice.
- cfg_resp_i / cfg_resp_v_i / cfg_resp_yumi_o  same shape, from config slice.
- mem_resp_o  out  cce_mem_msg_width_lp  merged response.
- mem_resp_v_o  out  1
- mem_resp_yumi_i  in  1
- unmapped_err_o  out  1  sticky unmapped-access flag (feature-dependent).

Behaviour:
- Reset: asynchronous assert/deassert via reset_n_i, active low. Tag FIFO empties, null buffer clears, unmapped_err_o=0. All v_o/yumi_o/ready_o outputs are 0 while reset_n_i=0.
- Decode: dev = local-address dev field of mem_cmd_i.header.addr.
  - dev==clint_dev_gp -> CLINT.
  - dev==cfg_dev_gp -> CFG.
  - Any other value -> NULL.
- Command path (combinational passthrough, zero latency):
  - mem_cmd_i drives both clint_cmd_o and cfg_cmd_o.
  - x_cmd_v_o = mem_cmd_v_i & sel==x & ~tag_full.
  - mem_cmd_ready_o = ~tag_full & (target ready); for NULL, target ready = null buffer empty.
- On accept: push the 2-bit destination tag; for NULL, also capture the header into the 1-entry null buffer.
- Response path:
  - The head tag selects the source.
  - mem_resp_v_o = tag_v & source resp valid (NULL: buffer valid).
  - mem_resp_o = source response. A NULL response is the captured header with msg_type/addr/payload/size/amo_no_return echoed and data all-zero.
  - Yumi goes only to the selected source: x_resp_yumi_o = mem_resp_yumi_i & head==x.
  - The tag pops on yumi.
- Ordering: a response from a non-head source is never forwarded or yumi'd; it waits.
- Full: with max_outstanding_p tags in flight, ready_o=0 regardless of targets.
- Simultaneous push and pop in the same cycle when full: not permitted; ready is based on the registered full, no bypass.
- Empty: mem_resp_v_o=0; source responses are ignored.
- Same-cycle null capture and null release: the release happens, then the new capture is allowed on the next cycle only.
- Ready/valid rules: v_o never depends on ready_i. ready_o may depend on v_i only through target selection.

Optional Feature:
- Macro BP_LOCAL_DEMUX_UNMAPPED_ERR_EN.
- Defined: unmapped_err_o sets on the first accepted NULL command and holds until reset. The NULL response data is all-ones instead of zero.
- Undefined: unmapped_err_o tied 0; NULL data is zero.

Decomposition:
- Shared package bp_me_pkg holds:
  - enum bp_local_demux_dest_e {e_dest_clint=0, e_dest_cfg=1, e_dest_null=2};
  - clint_dev_gp=1;
  - cfg_dev_gp=0.
- One sub-module, bp_local_tag_fifo: a 2-bit-wide, max_outstanding_p-deep FIFO with async active-low reset, exposing full/empty.

Test Plan:
- Single CLINT read to dev=1, mtime offset; CLINT responds 3 cycles later with data 0x40 -> mem_resp_o carries 0x40; clint_resp_yumi_o pulses once; tag FIFO empty.
- Back-to-back CFG read, then CLINT read; CLINT responds first -> CLINT response held (no yumi) until CFG responds; order out is CFG, then CLINT.
- Four CLINT commands with no responses -> fifth command sees mem_cmd_ready_o=0; one yumi -> ready returns the next cycle.
- Command to dev=7 -> response is the echoed header with data 0 (macro off) or all-ones with unmapped_err_o=1 (macro on).
- Assert reset_n_i mid-flight with 2 tags outstanding -> outputs drop immediately; after release, no stale response is emitted and a new command completes normally.
- clint_cmd_ready_i=0 for 10 cycles with a CLINT command pending -> no tag push; clint_cmd_v_o stays 1 throughout; accept on the first ready cycle.
